// File: rtl/uart_word_tx.sv
// uart_word_tx: drains 32-bit words from the output FIFO
// and sends each as optional header + 4 bytes, UART 8N1.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          HDR_EN       = 1'b1,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] FIRST_IDX =
    HDR_EN ? 3'd0 : 3'd1;
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [31:0]   word_reg;
  logic [2:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [CW-1:0] baud;
  logic          baud_done;

  assign baud_done = (baud == BAUD_LAST);

  function automatic logic [7:0] sel_byte(
    input logic [31:0] w,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    b = HDR_BYTE;
    unique case (1'b1)
      idx == 3'd1: b = w[7:0];
      idx == 3'd2: b = w[15:8];
      idx == 3'd3: b = w[23:16];
      idx == 3'd4: b = w[31:24];
      default:     b = HDR_BYTE;
    endcase
    return b;
  endfunction

  // Word sequencer: pop, latch, then start/data/stop per byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      word_reg   <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      baud       <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state      <= S_POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_POP: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          word_reg <= fifo_rd_data;
          byte_idx <= FIRST_IDX;
          shreg    <= sel_byte(fifo_rd_data, FIRST_IDX);
          baud     <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (byte_idx != LAST_IDX) begin
              byte_idx <= byte_idx + 3'd1;
              shreg    <= sel_byte(word_reg,
                                   byte_idx + 3'd1);
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              words_sent <= words_sent + 16'd1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: three builds (CPB 4/hdr, CPB 868/hdr,
// CPB 4/no hdr) checked against a frame-arithmetic model.
module tb_uart_word_tx;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_v    [N];
  logic        en_v     [N];
  logic        fempty_v [N];
  logic        rd_v     [N];
  logic        tx_v     [N];
  logic        busy_v   [N];
  logic [31:0] rdata_v  [N];
  logic [15:0] ws_v     [N];

  logic [31:0] fmem  [N][16];
  int          fhead [N];
  int          ftail [N];

  int          mk    [N];
  logic [31:0] mword [N];
  logic [15:0] mws   [N];

  logic        dact  [N];
  int          dc    [N];
  logic        dprev [N];
  logic [7:0]  dsh   [N];
  logic [7:0]  dq    [N][64];
  int          dn    [N];

  int rdcnt [N];
  int hirun [N];
  int lorun [N];
  int lasthi [N];
  int lastlo [N];

  int   nchk;
  int   npass;
  logic run_chk;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_empty
    assign fempty_v[g] = (fhead[g] == ftail[g]);
  end

  uart_word_tx #(
    .CLKS_PER_BIT(4), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)
  ) u0 (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]),
    .fifo_empty(fempty_v[0]), .fifo_rd_data(rdata_v[0]),
    .fifo_rd_en(rd_v[0]), .tx(tx_v[0]),
    .busy(busy_v[0]), .words_sent(ws_v[0])
  );

  uart_word_tx #(
    .CLKS_PER_BIT(868), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)
  ) u1 (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]),
    .fifo_empty(fempty_v[1]), .fifo_rd_data(rdata_v[1]),
    .fifo_rd_en(rd_v[1]), .tx(tx_v[1]),
    .busy(busy_v[1]), .words_sent(ws_v[1])
  );

  uart_word_tx #(
    .CLKS_PER_BIT(4), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)
  ) u2 (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]),
    .fifo_empty(fempty_v[2]), .fifo_rd_data(rdata_v[2]),
    .fifo_rd_en(rd_v[2]), .tx(tx_v[2]),
    .busy(busy_v[2]), .words_sent(ws_v[2])
  );

  function automatic int cpb_of(int i);
    return (i == 1) ? 868 : 4;
  endfunction

  function automatic bit hdr_of(int i);
    return (i != 2);
  endfunction

  function automatic int nbytes(int i);
    return hdr_of(i) ? 5 : 4;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] expv);
    nchk++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %h, want %h",
                  nm, act, expv);
  endtask

  // {tx, busy, rd_en} implied by position in the word frame.
  function automatic logic [2:0] exp_bits(int i);
    int c;
    int f;
    int by;
    int bt;
    int k;
    logic [7:0] b;
    logic t;
    if (rst_v[i] || mk[i] < 0) return 3'b100;
    if (mk[i] == 0) return 3'b111;
    if (mk[i] == 1) return 3'b110;
    c  = cpb_of(i);
    f  = mk[i] - 2;
    by = f / (10 * c);
    bt = (f % (10 * c)) / c;
    k  = hdr_of(i) ? by - 1 : by;
    if (k < 0) b = 8'hA5;
    else b = 8'(mword[i] >> (8 * k));
    if (bt == 0) t = 1'b0;
    else if (bt == 9) t = 1'b1;
    else t = b[bt-1];
    return {t, 2'b10};
  endfunction

  // Bench FIFO plus model advance, one step per clock.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_v[i] === 1'b1 && fhead[i] != ftail[i]) begin
        rdata_v[i] = fmem[i][fhead[i] % 16];
        fhead[i]++;
      end
      if (rst_v[i]) begin
        mk[i]  = -1;
        mws[i] = 16'd0;
      end else if (mk[i] < 0) begin
        if (en_v[i] && fhead[i] != ftail[i]) begin
          mk[i]    = 0;
          mword[i] = fmem[i][fhead[i] % 16];
        end
      end else begin
        mk[i]++;
        if (mk[i] == 2 + nbytes(i) * 10 * cpb_of(i)) begin
          mk[i]  = -1;
          mws[i] = mws[i] + 16'd1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < N; i++) begin
        logic [2:0]  e;
        logic [15:0] w;
        e = exp_bits(i);
        w = rst_v[i] ? 16'd0 : mws[i];
        chk($sformatf("u%0d.tx", i),
            32'(tx_v[i]), 32'(e[2]));
        chk($sformatf("u%0d.busy", i),
            32'(busy_v[i]), 32'(e[1]));
        chk($sformatf("u%0d.rd_en", i),
            32'(rd_v[i]), 32'(e[0]));
        chk($sformatf("u%0d.words_sent", i),
            32'(ws_v[i]), 32'(w));
      end
    end
  end

  // Independent UART receiver with bit-phase check.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int c;
      int b;
      c = cpb_of(i);
      if (rst_v[i]) begin
        dact[i] = 1'b0;
      end else if (!dact[i]) begin
        if (tx_v[i] === 1'b0) begin
          dact[i] = 1'b1;
          dc[i]   = 0;
        end
      end else begin
        dc[i]++;
        if (tx_v[i] !== dprev[i])
          chk($sformatf("u%0d.edge_phase", i),
              32'(dc[i] % c), 32'd0);
        if (dc[i] % c == c / 2) begin
          b = dc[i] / c;
          if (b == 0) begin
            chk($sformatf("u%0d.start_bit", i),
                32'(tx_v[i]), 32'd0);
          end else if (b <= 8) begin
            dsh[i][b-1] = tx_v[i];
          end else begin
            chk($sformatf("u%0d.stop_bit", i),
                32'(tx_v[i]), 32'd1);
            dq[i][dn[i] % 64] = dsh[i];
            dn[i]++;
            dact[i] = 1'b0;
          end
        end
      end
      dprev[i] = tx_v[i];
    end
  end

  // Pop-strobe count and busy run lengths.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_v[i] === 1'b1) rdcnt[i]++;
      if (busy_v[i] === 1'b1) begin
        if (lorun[i] > 0) lastlo[i] = lorun[i];
        lorun[i] = 0;
        hirun[i]++;
      end else begin
        if (hirun[i] > 0) lasthi[i] = hirun[i];
        hirun[i] = 0;
        lorun[i]++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int i, logic [31:0] w);
    fmem[i][ftail[i] % 16] = w;
    ftail[i]++;
  endtask

  task automatic wait_ws(int i, logic [15:0] tgt,
                         int budget);
    int t;
    t = 0;
    while (ws_v[i] !== tgt && t < budget) begin
      tick(1);
      t++;
    end
    chk($sformatf("u%0d.ws_wait", i),
        32'(ws_v[i]), 32'(tgt));
  endtask

  task automatic wait_busy(int i, int budget);
    int t;
    t = 0;
    while (busy_v[i] !== 1'b1 && t < budget) begin
      tick(1);
      t++;
    end
    chk($sformatf("u%0d.busy_wait", i),
        32'(busy_v[i]), 32'd1);
  endtask

  task automatic chk_bytes(int i, int start, int n,
                           logic [79:0] ev);
    for (int k = 0; k < n; k++)
      chk($sformatf("u%0d.byte%0d", i, start + k),
          32'(dq[i][(start + k) % 64]),
          32'(ev[8*(n-1-k) +: 8]));
  endtask

  initial begin
    int s;
    nchk    = 0;
    npass   = 0;
    run_chk = 1'b0;
    for (int i = 0; i < N; i++) begin
      rst_v[i]   = 1'b1;
      en_v[i]    = 1'b0;
      rdata_v[i] = 32'd0;
      fhead[i]   = 0;
      ftail[i]   = 0;
      mk[i]      = -1;
      mword[i]   = 32'd0;
      mws[i]     = 16'd0;
      dact[i]    = 1'b0;
      dc[i]      = 0;
      dprev[i]   = 1'b1;
      dsh[i]     = 8'd0;
      dn[i]      = 0;
      rdcnt[i]   = 0;
      hirun[i]   = 0;
      lorun[i]   = 0;
      lasthi[i]  = 0;
      lastlo[i]  = 0;
    end
    tick(3);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.rst_tx", i),
          32'(tx_v[i]), 32'd1);
      chk($sformatf("u%0d.rst_busy", i),
          32'(busy_v[i]), 32'd0);
      chk($sformatf("u%0d.rst_rd", i),
          32'(rd_v[i]), 32'd0);
      chk($sformatf("u%0d.rst_ws", i),
          32'(ws_v[i]), 32'd0);
      rst_v[i] = 1'b0;
    end
    run_chk = 1'b1;

    push(1, 32'hCAFE0123);
    en_v[1] = 1'b1;

    en_v[0] = 1'b1;
    tick(1000);
    chk("empty_rd_cnt", 32'(rdcnt[0]), 32'd0);
    chk("empty_tx", 32'(tx_v[0]), 32'd1);
    chk("empty_busy", 32'(busy_v[0]), 32'd0);

    push(0, 32'h12345678);
    wait_ws(0, 16'd1, 400);
    tick(2);
    chk("w1_rd_cnt", 32'(rdcnt[0]), 32'd1);
    chk("w1_busy_len", 32'(lasthi[0]), 32'd202);
    chk("w1_nbytes", 32'(dn[0]), 32'd5);
    chk_bytes(0, 0, 5, 80'hA5_78_56_34_12);

    push(0, 32'hDEADBEEF);
    push(0, 32'h00000001);
    wait_ws(0, 16'd3, 800);
    tick(2);
    chk("w2_rd_cnt", 32'(rdcnt[0]), 32'd3);
    chk("w2_gap", 32'(lastlo[0]), 32'd1);
    chk("w2_busy_len", 32'(lasthi[0]), 32'd202);
    chk_bytes(0, 5, 10,
              80'hA5_EF_BE_AD_DE_A5_01_00_00_00);

    s = dn[0];
    push(0, 32'h11223344);
    push(0, 32'h55667788);
    wait_busy(0, 10);
    tick(94);
    rst_v[0] = 1'b1;
    #1;
    chk("arst_tx", 32'(tx_v[0]), 32'd1);
    chk("arst_busy", 32'(busy_v[0]), 32'd0);
    chk("arst_ws", 32'(ws_v[0]), 32'd0);
    tick(2);
    rst_v[0] = 1'b0;
    wait_ws(0, 16'd1, 400);
    tick(2);
    chk("arst_rd_cnt", 32'(rdcnt[0]), 32'd5);
    chk("arst_nbytes", 32'(dn[0] - s), 32'd7);
    chk_bytes(0, s, 7, 80'hA5_44_A5_88_77_66_55);

    s = dn[0];
    push(0, 32'hAAAA5555);
    push(0, 32'h0F0F0F0F);
    wait_busy(0, 10);
    tick(50);
    en_v[0] = 1'b0;
    wait_ws(0, 16'd2, 400);
    tick(300);
    chk("en_rd_cnt", 32'(rdcnt[0]), 32'd6);
    chk("en_busy", 32'(busy_v[0]), 32'd0);
    chk("en_fifo_kept", 32'(fempty_v[0]), 32'd0);
    en_v[0] = 1'b1;
    wait_ws(0, 16'd3, 400);
    tick(2);
    chk("en2_rd_cnt", 32'(rdcnt[0]), 32'd7);
    chk_bytes(0, s, 10,
              80'hA5_55_55_AA_AA_A5_0F_0F_0F_0F);

    push(2, 32'h89ABCDEF);
    en_v[2] = 1'b1;
    wait_ws(2, 16'd1, 400);
    tick(2);
    chk("nohdr_busy_len", 32'(lasthi[2]), 32'd162);
    chk("nohdr_nbytes", 32'(dn[2]), 32'd4);
    chk("nohdr_rd_cnt", 32'(rdcnt[2]), 32'd1);
    chk_bytes(2, 0, 4, 80'hEF_CD_AB_89);

    wait_ws(1, 16'd1, 50000);
    tick(2);
    chk("slow_busy_len", 32'(lasthi[1]), 32'd43402);
    chk("slow_nbytes", 32'(dn[1]), 32'd5);
    chk("slow_rd_cnt", 32'(rdcnt[1]), 32'd1);
    chk_bytes(1, 0, 5, 80'hA5_23_01_FE_CA);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
